// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit big-endian words and writes them to instruction RAM.
// Define IMEM_LOADER_CHECKSUM_EN to require a 4-byte sum trailer that gates the CPU release.
module imem_loader #(
  parameter int DEPTH_LOG2 = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DEPTH_LOG2:0]   len_words_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_hold_o
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [2:0] IDLE = 3'd0, RECV = 3'd1, WRITE = 3'd2, DONE = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] FIN = CHECK;
`else
  localparam logic [2:0] FIN = DONE;
`endif
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, idx_inc;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   word_q, word_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, shifted;
  logic          done_q, done_d, err_q, err_d, hold_q, hold_d, we_q, we_d, ready_q, hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
`endif

  assign hs      = ready_q & byte_valid_i;
  assign shifted = {word_q, byte_data_i};
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE: if (start_i) begin
        len_d   = (len_words_i > MAX_LEN) ? MAX_LEN : len_words_i;
        idx_d   = '0;
        cnt_d   = '0;
        word_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
        state_d = (len_words_i == '0) ? FIN : RECV;
      end
      RECV: if (hs) begin
        word_d = shifted[23:0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == 2'd3) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = 32'({idx_q, 2'b00});
          wdata_d = shifted;
        end
      end
      WRITE: begin
        idx_d   = idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
        state_d = (idx_inc == len_q) ? FIN : RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (hs) begin
        word_d = shifted[23:0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
          err_d   = shifted != sum_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // DONE releases the CPU only when no checksum error was flagged
    if (state_d == DONE) begin
      done_d = 1'b1;
      hold_d = err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      ready_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ready_q <= (state_d == RECV) || (state_d == CHECK);
      sum_q   <= sum_d;
`else
      ready_q <= state_d == RECV;
`endif
    end
  end

  assign byte_ready_o = ready_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q != IDLE) && (state_q != DONE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_hold_o   = hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench with a word-level scoreboard built from the image bytes.
module tb_imem_loader;
  localparam int D  = 3;
  localparam int LW = D + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, byte_valid = 1'b0;
  logic [LW-1:0] len_words = '0;
  logic [7:0] byte_data = '0;
  logic byte_ready, mem_we, busy, done, err, cpu_hold;
  logic [31:0] mem_addr, mem_wdata;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] log_addr[$], log_data[$];
  int log_cyc[$];
  logic [7:0] img [64];

  imem_loader #(.DEPTH_LOG2(D)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_words_i(len_words),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .cpu_hold_o(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // every-cycle compare against the expected write stream and output invariants
  always @(negedge clk) if (!rst) begin
    logic [63:0] e;
    chk("ready_with_we", 32'(byte_ready & mem_we), 0);
    chk("ready_not_busy", 32'(byte_ready & ~busy), 0);
    chk("done_with_busy", 32'(done & busy), 0);
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_start(input int len);
    start = 1'b1;
    len_words = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && t < 40) begin @(posedge clk); #1; t++; end
    if (!byte_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_timeout: got byte_ready 0 expected 1");
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic load(input int len_req, input int nw, input int maxgap, input logic bad, input logic glitch);
    logic [31:0] sum, w;
    sum = 0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    do_start(len_req);
    if (glitch) begin
      do_start(len_req + 1);
      chk("busy_after_glitch", 32'(busy), 1);
    end
    for (int k = 0; k < nw; k++) begin
      w = 0;
      for (int j = 0; j < 4; j++) w = w * 256 + 32'(img[4*k+j]);
      sum += w;
      exp_q.push_back({32'(4 * k), w});
      for (int j = 0; j < 4; j++) send_byte(img[4*k+j], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum += 32'(bad);
    for (int j = 3; j >= 0; j--) send_byte(sum[8*j +: 8], 0);
    chk("done_after_trailer", 32'(done), 1);
    chk("err_after_trailer", 32'(err), 32'(bad));
    chk("hold_after_trailer", 32'(cpu_hold), 32'(bad));
`else
    if (nw > 0) begin
      chk("we_after_last_byte", 32'(mem_we), 1);
      chk("done_too_early", 32'(done), 0);
      @(posedge clk); #1;
    end
    chk("done_final", 32'(done), 1);
    chk("hold_final", 32'(cpu_hold), 0);
    chk("err_final", 32'(err), 32'(bad));
`endif
    chk("busy_final", 32'(busy), 0);
    chk("writes_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    repeat (3) @(posedge clk); #1;
    chk("rst_hold", 32'(cpu_hold), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("idle_hold", 32'(cpu_hold), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(byte_ready), 0);

    v = 64'h12345678AABBCCDD;
    for (int i = 0; i < 8; i++) img[i] = v[63-8*i -: 8];
    load(2, 2, 0, 1'b0, 1'b0);
    chk("lit_count", 32'(log_data.size()), 2);
    if (log_data.size() == 2) begin
      chk("lit_a0", log_addr[0], 32'h0);
      chk("lit_d0", log_data[0], 32'h12345678);
      chk("lit_a1", log_addr[1], 32'h4);
      chk("lit_d1", log_data[1], 32'hAABBCCDD);
      chk("lit_spacing", 32'(log_cyc[1] - log_cyc[0]), 5);
    end

    load(2, 2, 3, 1'b0, 1'b0);
    chk("gap_count", 32'(log_data.size()), 2);
    if (log_data.size() == 2) begin
      chk("gap_d0", log_data[0], 32'h12345678);
      chk("gap_d1", log_data[1], 32'hAABBCCDD);
    end

    do_start(1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(byte_ready), 0);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_hold", 32'(cpu_hold), 1);
    chk("abort_addr", mem_addr, 0);
    chk("abort_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    v = 64'hDEADBEEF00000000;
    for (int i = 0; i < 4; i++) img[i] = v[63-8*i -: 8];
    load(1, 1, 0, 1'b0, 1'b0);
    chk("fresh_count", 32'(log_data.size()), 1);
    if (log_data.size() == 1) begin
      chk("fresh_addr", log_addr[0], 32'h0);
      chk("fresh_data", log_data[0], 32'hDEADBEEF);
    end

    load(0, 0, 0, 1'b0, 1'b0);
    chk("len0_no_write", 32'(log_data.size()), 0);

    load(1, 1, 1, 1'b0, 1'b1);
    chk("glitch_count", 32'(log_data.size()), 1);

    for (int i = 0; i < 32; i++) img[i] = 8'(i * 29 + 5);
    load(15, 8, 0, 1'b0, 1'b0);
    chk("clamp_count", 32'(log_data.size()), 8);
    if (log_data.size() == 8) begin
      chk("clamp_last_addr", log_addr[7], 32'h1C);
      chk("clamp_w0", log_data[0], 32'h05223F5C);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    v = 64'h0000000100000000;
    for (int i = 0; i < 4; i++) img[i] = v[63-8*i -: 8];
    load(1, 1, 0, 1'b0, 1'b0);
    load(1, 1, 0, 1'b1, 1'b0);
    chk("bad_sum_done", 32'(done), 1);
    chk("bad_sum_hold", 32'(cpu_hold), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side counterpart of the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. It writes each word into instruction RAM at word-aligned byte addresses, the same address format the fetch stage presents as `pc`. It holds the CPU off (`cpu_hold`) until the image is fully loaded and, optionally, checksum-verified.

## Interface
Parameters:
- `DEPTH_LOG2`, default 17: log2 of the instruction memory depth in words.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load session.
- `len_words`  in  DEPTH_LOG2+1  number of words to load; sampled on the accepted `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  image byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction RAM write strobe, one cycle per word.
- `mem_addr`  out  `DataWidth` (32)  byte address, `{idx, 2'b00}`, zero-extended.
- `mem_wdata`  out  `DataWidth` (32)  packed word.
- `busy`  out  1  a session is in progress.
- `done`  out  1  sticky; the last session completed.
- `err`  out  1  sticky checksum mismatch. Tied to 0 when the macro is absent.
- `cpu_hold`  out  1  high keeps the CPU fetch disabled.

## Operation
States: IDLE, RECV, WRITE, CHECK (macro only), DONE.

- **IDLE / DONE:**
  - `start` = 1 latches `len_words`, clears `idx`, the byte counter, `done`, `err` and the accumulator, and sets `cpu_hold` = 1.
  - Next state is RECV if `len_words` != 0.
  - If `len_words` = 0, next state is CHECK (macro) or DONE.
- **RECV:**
  - `byte_ready` = 1.
  - Each handshake (`byte_valid && byte_ready`) shifts the byte into the word, first byte into [31:24], last byte into [7:0].
  - On the 4th byte the state becomes WRITE.
- **WRITE:**
  - `byte_ready` = 0; `mem_we` = 1; `mem_addr` = `idx*4`; `mem_wdata` = the packed word.
  - `idx` increments.
  - If the new `idx` equals the latched length, next state is CHECK or DONE; otherwise RECV.
- **CHECK:**
  - Receives 4 bytes in the same big-endian order and compares them with the 32-bit modular sum of all written words.
  - Next state is DONE; `err` = 1 on mismatch.
- **DONE:**
  - `done` = 1.
  - `cpu_hold` = `err`: the CPU is released only on success.
- `start` while `busy` is ignored.
- `len_words` greater than 2^DEPTH_LOG2 is clamped to 2^DEPTH_LOG2.
- `busy` = 1 in RECV, WRITE and CHECK.
- `byte_ready` is 0 outside RECV and CHECK.

## Timing
- Reset values:
  - state IDLE;
  - `byte_ready`, `mem_we`, `busy`, `done`, `err` = 0;
  - `mem_addr`, `mem_wdata` = 0;
  - `cpu_hold` = 1.
- `rst` mid-session aborts immediately and asynchronously to the reset values. Partially written words in RAM are left as-is.
- `byte_ready` is a registered Moore output of the state; there is no combinational path from `byte_valid`.
- Sustained throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- `mem_addr` and `mem_wdata` are registered, valid only while `mem_we` = 1, and hold their last value otherwise.
- Latency from the last image byte to `done`:
  - macro absent: 2 cycles (WRITE, then DONE registered);
  - macro present: 1 cycle after the 4th checksum byte.
- `byte_valid` with no handshake in progress causes no state change. Bubbles between bytes are allowed in any number.
- `idx` width is DEPTH_LOG2+1, so a full-depth load does not wrap before the compare.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHECK state present; a 4-byte trailer is required after the image.
  - `err` is functional; a mismatch leaves `cpu_hold` = 1.
- Not defined:
  - no CHECK state and no accumulator;
  - `err` = 0 constantly;
  - the last WRITE goes straight to DONE.

## Test plan
- Reset, no start:
  - `cpu_hold` = 1, `busy` = 0, `byte_ready` = 0, `mem_we` never asserted.
- `start`, `len_words` = 2, bytes 12 34 56 78 AA BB CC DD sent back-to-back (macro off):
  - write 0x12345678 @ 0x0, then 0xAABBCCDD @ 0x4, 5 cycles apart;
  - `done` = 1 and `cpu_hold` = 0 two cycles after the last byte.
- Same stimulus with random `byte_valid` gaps of 0–3 cycles: identical writes; `byte_ready` is never high in WRITE.
- Macro on, `len_words` = 1, word 00000001:
  - trailer 00 00 00 01 gives `err` = 0, `cpu_hold` = 0;
  - trailer 00 00 00 02 gives `err` = 1, `cpu_hold` = 1, `done` = 1.
- `rst` pulsed after 2 bytes of word 1:
  - all outputs return to reset values;
  - a fresh `start` with `len_words` = 1 writes @ 0x0.
- `len_words` = 0: reaches DONE with no `mem_we`; a second `start` issued while `busy` is ignored.
